// File: rtl/dmem_lsu_if.sv
// Request/response bus between the execute stage and the dmem_lsu data memory.
// The master modport is the pipeline side; the slave modport is the memory side.
interface dmem_lsu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [1:0]            ReqSize;
  logic                  ReqUnsigned;
  logic [DATA_WIDTH-1:0] ALUresult;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RespValid;
  logic                  RespReady;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  RespErr;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ALUresult, WriteData, RespReady,
    input  ReqReady, RespValid, ReadData, RespErr
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ALUresult, WriteData, RespReady,
    output ReqReady, RespValid, ReadData, RespErr
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressable RV32 data memory with load/store unit, valid/ready handshakes and
// configurable read latency. Define DMEM_MISALIGN_ERR_EN to fault misaligned/reserved accesses.
module dmem_lsu #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int READ_LATENCY  = 1,
  parameter int DATA_WIDTH    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.slave  bus
);

  localparam int WORDS = 2 ** (ADDRESS_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_n;
  logic [3:0]              cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_n;
  logic                    err_q, err_n;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic [ADDRESS_WIDTH-3:0] word_idx;
  logic [1:0]               offset;
  logic [1:0]               eff_offset;
  logic [3:0]               lane_en;
  logic [DATA_WIDTH-1:0]    lane_data;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     fault;
  logic                     mem_we;
  logic                     unused_addr;

  // Half accesses snap to the containing half-word, word/reserved accesses to the word.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   align_offset = off;
      2'b01:   align_offset = {off[1], 1'b0};
      default: align_offset = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic                  uns,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   load_extend = uns ? {{(DATA_WIDTH-8){1'b0}}, b}  : {{(DATA_WIDTH-8){b[7]}}, b};
      2'b01:   load_extend = uns ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign word_idx    = bus.ALUresult[ADDRESS_WIDTH-1:2];
  assign offset      = bus.ALUresult[1:0];
  assign unused_addr = ^bus.ALUresult[DATA_WIDTH-1:ADDRESS_WIDTH];
  assign eff_offset  = align_offset(bus.ReqSize, offset);
  assign lane_en     = lane_mask(bus.ReqSize, eff_offset);
  assign rd_word     = mem[word_idx];

  // Store data replicated across lanes so the lane mask alone selects placement.
  always_comb begin
    case (bus.ReqSize)
      2'b00:   lane_data = {4{bus.WriteData[7:0]}};
      2'b01:   lane_data = {2{bus.WriteData[15:0]}};
      default: lane_data = bus.WriteData;
    endcase
  end

`ifdef DMEM_MISALIGN_ERR_EN
  assign fault = ((bus.ReqSize == 2'b01) && offset[0])
               || ((bus.ReqSize == 2'b10) && (offset != 2'b00))
               || (bus.ReqSize == 2'b11);
`else
  assign fault = 1'b0;
`endif

  assign bus.ReqReady  = (state_q == IDLE);
  assign bus.RespValid = (state_q == RESP);
  assign bus.ReadData  = rdata_q;
  assign bus.RespErr   = err_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ReqValid) begin
          err_n = fault;
          if (bus.ReqWrite) begin
            mem_we  = ~fault;
            rdata_n = '0;
            state_n = RESP;
          end else begin
            rdata_n = fault ? '0 : load_extend(rd_word, bus.ReqSize, bus.ReqUnsigned, eff_offset);
            if (READ_LATENCY == 1) begin
              state_n = RESP;
            end else begin
              state_n = WAIT;
              cnt_n   = 4'(READ_LATENCY - 1);
            end
          end
        end
      end
      WAIT: begin
        cnt_n = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_n = RESP;
      end
      RESP: begin
        if (bus.RespReady) begin
          state_n = IDLE;
          rdata_n = '0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  // Storage is not reset; a store commits at its accept edge regardless of later resets.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu (ADDRESS_WIDTH=12, READ_LATENCY=3); expectations follow
// DMEM_MISALIGN_ERR_EN when it is defined for the build.
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  dmem_lsu_if #(.DATA_WIDTH(32)) bus ();

  dmem_lsu #(.ADDRESS_WIDTH(12), .READ_LATENCY(3), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one request at a falling edge, then complete its response handshake.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic ero, output int lato);
    @(negedge clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = w; bus.ReqSize = sz; bus.ReqUnsigned = u;
    bus.ALUresult = a; bus.WriteData = wd;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    lato = 1;
    for (int i = 0; i < 20 && bus.RespValid !== 1'b1; i++) begin
      @(posedge clk); #1;
      lato++;
    end
    if (bus.RespValid !== 1'b1) begin
      rdo = 32'hBAD0BAD0; ero = 1'bx; lato = -1;
    end else begin
      rdo = bus.ReadData; ero = bus.RespErr;
      bus.RespReady = 1'b1;
      @(posedge clk); #1;
      bus.RespReady = 1'b0;
    end
  endtask

  task automatic test_reset;
    #1;
    if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL rst_reqready got=%b exp=1", bus.ReqReady); end
    checks++;
    if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL rst_respvalid got=%b exp=0", bus.RespValid); end
    checks++;
    if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rst_readdata got=%h exp=0", bus.ReadData); end
    checks++;
    if (bus.RespErr !== 1'b0) begin errors++; $display("FAIL rst_resperr got=%b exp=0", bus.RespErr); end
    checks++;
  endtask

  task automatic test_word;
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, rd, er, lat);
    if (rd !== 32'h0) begin errors++; $display("FAIL sw_readdata got=%h exp=0", rd); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sw_latency got=%0d exp=1", lat); end
    checks++;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL lw_err got=%b exp=0", er); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    checks++;
  endtask

  task automatic test_byte;
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h12345680, rd, er, lat);
    if (lat !== 1) begin errors++; $display("FAIL sb_latency got=%0d exp=1", lat); end
    checks++;
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, er, lat);
    if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", rd); end
    checks++;
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, er, lat);
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", rd); end
    checks++;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    if (rd !== 32'h80000000) begin errors++; $display("FAIL lw_after_sb got=%h exp=80000000", rd); end
    checks++;
  endtask

  task automatic test_half;
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hAABBCCDD, rd, er, lat);
    do_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h99991234, rd, er, lat);
    do_req(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, rd, er, lat);
    if (rd !== 32'h00001234) begin errors++; $display("FAIL lh_hi got=%h exp=00001234", rd); end
    checks++;
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, er, lat);
    if (rd !== 32'h1234CCDD) begin errors++; $display("FAIL lw_after_sh got=%h exp=1234ccdd", rd); end
    checks++;
    do_req(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, rd, er, lat);
    if (rd !== 32'hFFFFCCDD) begin errors++; $display("FAIL lh_lo got=%h exp=ffffccdd", rd); end
    checks++;
    do_req(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, rd, er, lat);
    if (rd !== 32'h0000CCDD) begin errors++; $display("FAIL lhu_lo got=%h exp=0000ccdd", rd); end
    checks++;
  endtask

  task automatic test_wrap;
    // 0x1100 aliases 0x100 with a 12-bit byte address
    do_req(1'b0, 2'b10, 1'b0, 32'h00001100, 32'h0, rd, er, lat);
    if (rd !== 32'h80000000) begin errors++; $display("FAIL wrap_load got=%h exp=80000000", rd); end
    checks++;
  endtask

  task automatic test_stall;
    int k;
    @(negedge clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b10; bus.ReqUnsigned = 1'b0;
    bus.ALUresult = 32'h200;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    k = 0;
    while (bus.RespValid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    if (bus.RespValid !== 1'b1) begin errors++; $display("FAIL stall_resp_timeout got=%b exp=1", bus.RespValid); end
    checks++;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.WriteData = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.RespValid !== 1'b1) begin errors++; $display("FAIL stall_respvalid[%0d] got=%b exp=1", c, bus.RespValid); end
      checks++;
      if (bus.ReadData !== 32'h1234CCDD) begin errors++; $display("FAIL stall_readdata[%0d] got=%h exp=1234ccdd", c, bus.ReadData); end
      checks++;
      if (bus.ReqReady !== 1'b0) begin errors++; $display("FAIL stall_reqready[%0d] got=%b exp=0", c, bus.ReqReady); end
      checks++;
    end
    bus.RespReady = 1'b1;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0; bus.RespReady = 1'b0;
    if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL release_respvalid got=%b exp=0", bus.RespValid); end
    checks++;
    if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL release_readdata got=%h exp=0", bus.ReadData); end
    checks++;
    if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL release_reqready got=%b exp=1", bus.ReqReady); end
    checks++;
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, er, lat);
    if (rd !== 32'h1234CCDD) begin errors++; $display("FAIL ignored_store got=%h exp=1234ccdd", rd); end
    checks++;
  endtask

  task automatic test_misalign;
    do_req(1'b1, 2'b10, 1'b0, 32'h300, 32'h11223344, rd, er, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    do_req(1'b1, 2'b10, 1'b0, 32'h301, 32'hFFFFFFFF, rd, er, lat);
    if (er !== 1'b1) begin errors++; $display("FAIL sw_mis_err got=%b exp=1", er); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL sw_mis_latency got=%0d exp=1", lat); end
    checks++;
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, rd, er, lat);
    if (rd !== 32'h11223344) begin errors++; $display("FAIL sw_mis_suppressed got=%h exp=11223344", rd); end
    checks++;
    do_req(1'b0, 2'b01, 1'b0, 32'h301, 32'h0, rd, er, lat);
    if (rd !== 32'h0) begin errors++; $display("FAIL lh_mis_data got=%h exp=0", rd); end
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL lh_mis_err got=%b exp=1", er); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lh_mis_latency got=%0d exp=3", lat); end
    checks++;
    do_req(1'b0, 2'b11, 1'b0, 32'h300, 32'h0, rd, er, lat);
    if (er !== 1'b1) begin errors++; $display("FAIL rsvd_err got=%b exp=1", er); end
    checks++;
`else
    do_req(1'b0, 2'b01, 1'b0, 32'h301, 32'h0, rd, er, lat);
    if (rd !== 32'h00003344) begin errors++; $display("FAIL lh_mis_data got=%h exp=00003344", rd); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL lh_mis_err got=%b exp=0", er); end
    checks++;
    do_req(1'b1, 2'b11, 1'b0, 32'h302, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, rd, er, lat);
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rsvd_as_word got=%h exp=cafef00d", rd); end
    checks++;
`endif
  endtask

  task automatic test_reset_mid;
    // Store accepted, then reset while its response is pending
    @(negedge clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqSize = 2'b10; bus.ReqUnsigned = 1'b0;
    bus.ALUresult = 32'h400; bus.WriteData = 32'h5A5A5A5A;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    rst_n = 1'b0; #1;
    if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL rst_resp_drop got=%b exp=0", bus.RespValid); end
    checks++;
    @(negedge clk); rst_n = 1'b1;
    // Load accepted, reset while in WAIT
    @(negedge clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ALUresult = 32'h400;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    #2 rst_n = 1'b0; #1;
    if (bus.RespValid !== 1'b0) begin errors++; $display("FAIL rst_wait_respvalid got=%b exp=0", bus.RespValid); end
    checks++;
    if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rst_wait_readdata got=%h exp=0", bus.ReadData); end
    checks++;
    @(negedge clk); rst_n = 1'b1; #1;
    if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL rst_wait_reqready got=%b exp=1", bus.ReqReady); end
    checks++;
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lat);
    if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL store_survives_reset got=%h exp=5a5a5a5a", rd); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
    checks++;
  endtask

  initial begin
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b00; bus.ReqUnsigned = 1'b0;
    bus.ALUresult = 32'h0; bus.WriteData = 32'h0; bus.RespReady = 1'b0;
    repeat (2) @(posedge clk);
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_word;
    test_byte;
    test_half;
    test_wrap;
    test_stall;
    test_misalign;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised byte-addressable RV32 data memory with a built-in load/store unit.
- Successor to the single-cycle word-only data memory.
- Adds byte, half and word accesses, sign/zero extension and a configurable read latency.
- Uses valid/ready request and response handshakes so the pipeline can stall on memory.
- Sits between the execute stage (address from ALU) and writeback.

Parameters:
- ADDRESS_WIDTH, 20, byte-address bits used; storage = 2**(ADDRESS_WIDTH-2) words of 32 bits.
- READ_LATENCY, 1, cycles from request-accept edge to RespValid for reads; legal range 1..15.
- DATA_WIDTH, 32, data path width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  block can accept a request this cycle.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqSize  input  2  00 byte, 01 half, 10 word, 11 reserved (funct3[1:0]).
- ReqUnsigned  input  1  load zero-extends when 1 (funct3[2]).
- ALUresult  input  DATA_WIDTH  byte address.
- WriteData  input  DATA_WIDTH  store data, right-aligned.
- RespValid  output  1  response available.
- RespReady  input  1  consumer takes the response.
- ReadData  output  DATA_WIDTH  extended load result; 0 for stores.
- RespErr  output  1  access fault (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: state IDLE, ReqReady=1, RespValid=0, ReadData=0, RespErr=0, latency counter=0.
  - Memory contents are not reset.
- Addressing:
  - Word index = ALUresult[ADDRESS_WIDTH-1:2].
  - Byte offset = ALUresult[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 2**ADDRESS_WIDTH.
  - Byte lanes are little-endian.
- FSM states: IDLE, WAIT, RESP. ReqReady=1 only in IDLE.
- Request accept = ReqValid & ReqReady at a rising edge. On accept, latch ReqWrite, ReqSize, ReqUnsigned and the offset.
- Store on accept:
  - Write only the addressed byte lanes at that same edge.
  - Byte: lane = offset, data = WriteData[7:0].
  - Half: lanes offset and offset+1, data = WriteData[15:0].
  - Word: all 4 lanes.
  - Next state is RESP with ReadData=0.
- Load on accept:
  - Read the addressed word at the accept edge.
  - Extract the byte or half at the offset.
  - Sign-extend, or zero-extend if ReqUnsigned; word loads ignore ReqUnsigned.
  - Latch the result into ReadData.
  - If READ_LATENCY=1, go to RESP. Otherwise go to WAIT with counter=READ_LATENCY-1.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RespValid therefore rises exactly READ_LATENCY cycles after the accept edge.
- RESP:
  - RespValid=1; ReadData and RespErr are held stable.
  - On RespValid & RespReady, go to IDLE, clear RespValid and clear ReadData to 0.
  - A new request can be accepted no earlier than the cycle after the response handshake, so there is no back-to-back overlap.
- Stores always respond 1 cycle after accept, independent of READ_LATENCY.
- Requests presented while ReqReady=0 are ignored; the requester must hold them.
- Reset mid-operation:
  - Any pending response is discarded.
  - A store already accepted stays committed.
  - A load in WAIT or RESP is lost.
- Load of a location written by the immediately preceding store returns the new data, because the store commits before the load can be accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: an access is faulting when any of these hold:
  - half with ALUresult[0]=1;
  - word with ALUresult[1:0]!=0;
  - ReqSize=11.
- Faulting access, defined case:
  - Store: suppressed; no lanes written.
  - Load: ReadData=0.
  - RespErr=1 in RESP.
  - Response timing is identical to the non-faulting case.
- Not defined:
  - RespErr is tied 0.
  - Half uses offset {ALUresult[1],0}; word uses offset 0.
  - ReqSize=11 is treated as word.

Test Plan:
- Store word 0xDEADBEEF @0x100, then load word @0x100 → ReadData=0xDEADBEEF, RespErr=0; with READ_LATENCY=3, RespValid rises 3 cycles after the load accept edge.
- Store byte 0x80 @0x103 over 0x00000000, then LB @0x103 → 0xFFFFFF80; LBU → 0x00000080; LW @0x100 → 0x80000000.
- Store half 0x1234 @0x202, then LH @0x202 → 0x00001234; word @0x200 shows lanes 0–1 untouched.
- Hold RespReady=0 for 5 cycles in RESP → RespValid and ReadData stable, ReqReady=0, new ReqValid ignored; RespReady=1 → IDLE next cycle.
- DMEM_MISALIGN_ERR_EN defined: SW @0x301 → RespErr=1, memory @0x300 unchanged; LH @0x301 → ReadData=0, RespErr=1. Undefined: LH @0x301 returns the half @0x300, RespErr=0.
- Assert rst_n=0 while in WAIT → RespValid=0, ReadData=0 immediately (asynchronous); after release, ReqReady=1 and an earlier committed store is still readable.
